// File: rtl/uart_io_pkg.sv
// rtl/uart_io_pkg.sv - shared state encodings and byte helpers for the UART exec-stage responder
package uart_io_pkg;

  // 2-bit state encodings for the TX and RX engines
  localparam logic [1:0] ST_T_IDLE    = 2'd0;
  localparam logic [1:0] ST_T_SEND    = 2'd1;
  localparam logic [1:0] ST_T_GAP     = 2'd2;
  localparam logic [1:0] ST_R_IDLE    = 2'd0;
  localparam logic [1:0] ST_R_COLLECT = 2'd1;
  localparam logic [1:0] ST_R_DONE    = 2'd2;

  typedef enum logic [1:0] {
    T_IDLE = ST_T_IDLE,
    T_SEND = ST_T_SEND,
    T_GAP  = ST_T_GAP
  } tx_state_e;

  typedef enum logic [1:0] {
    R_IDLE    = ST_R_IDLE,
    R_COLLECT = ST_R_COLLECT,
    R_DONE    = ST_R_DONE
  } rx_state_e;

  // Size code to byte count (1..4)
  function automatic logic [2:0] nbytes(input logic [1:0] sz);
    return {1'b0, sz} + 3'd1;
  endfunction

  // Byte idx of a word counted from the LSB; with idx = remaining-1 this
  // walks a big-endian word from its most significant used byte downwards
  function automatic logic [7:0] be_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_io_fifo.sv
// rtl/uart_io_fifo.sv - first-word-fall-through byte FIFO with wrap-bit pointers
module uart_io_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [7:0]          mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;

  // Pointers are equal when empty; same index but different wrap bit when full
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                 (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign dout  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  // Pointer advance; the caller only pushes/pops when legal
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  end

  // Pointer registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= din;
    end
  end

endmodule

// File: rtl/uart_io_ctrl.sv
// rtl/uart_io_ctrl.sv - UART word/byte responder; UART_IO_LOOPBACK_EN routes TX bytes into the RX FIFO
module uart_io_ctrl
  import uart_io_pkg::*;
#(
  parameter int RX_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        uart_wenable,
  input  logic [1:0]  uart_wsz,
  input  logic [31:0] uart_wd,
  output logic        uart_wdone,
  input  logic        uart_renable,
  input  logic [1:0]  uart_rsz,
  output logic [31:0] uart_rd,
  output logic        uart_rdone,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_overflow
);

  tx_state_e   tx_state_q, tx_state_d;
  logic [31:0] wd_q, wd_d;
  logic [2:0]  tx_left_q, tx_left_d;
  logic        wdone_q, wdone_d;
  logic        tx_fire;
  logic [7:0]  tx_byte;
  logic        tx_busy_eff;

  rx_state_e   rx_state_q, rx_state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] rd_q, rd_d;
  logic [2:0]  rx_left_q, rx_left_d;
  logic        rdone_q, rdone_d;
  logic        ovf_q, ovf_d;

  logic        push_req;
  logic [7:0]  push_byte;
  logic        fifo_push, fifo_pop;
  logic [7:0]  fifo_dout;
  logic        fifo_empty, fifo_full;

  // Next byte to send is the most significant one still pending
  assign tx_byte = be_byte(wd_q, tx_left_q[1:0] - 2'd1);

`ifdef UART_IO_LOOPBACK_EN
  logic loopback_unused;
  assign loopback_unused = ^{tx_busy, rx_valid, rx_data};
  assign tx_busy_eff = 1'b0;
  assign push_req    = tx_fire;
  assign push_byte   = tx_byte;
  assign tx_start    = 1'b0;
  assign tx_data     = 8'h00;
`else
  assign tx_busy_eff = tx_busy;
  assign push_req    = rx_valid;
  assign push_byte   = rx_data;
  assign tx_start    = tx_fire;
  assign tx_data     = (tx_state_q == T_SEND) ? tx_byte : 8'h00;
`endif

  // A pop in the same cycle frees a slot, so a full FIFO can still accept
  assign fifo_push = push_req && (!fifo_full || fifo_pop);

  assign uart_wdone  = wdone_q;
  assign uart_rdone  = rdone_q;
  assign uart_rd     = rd_q;
  assign rx_overflow = ovf_q;

  // TX engine: latch the word, hand bytes out one per free PHY slot, one gap cycle after each
  always_comb begin
    tx_state_d = tx_state_q;
    wd_d       = wd_q;
    tx_left_d  = tx_left_q;
    wdone_d    = 1'b0;
    tx_fire    = 1'b0;
    case (tx_state_q)
      T_IDLE: begin
        if (uart_wenable) begin
          wd_d       = uart_wd;
          tx_left_d  = nbytes(uart_wsz);
          tx_state_d = T_SEND;
        end
      end
      T_SEND: begin
        if (!tx_busy_eff) begin
          tx_fire    = 1'b1;
          tx_left_d  = tx_left_q - 3'd1;
          wdone_d    = (tx_left_q == 3'd1);
          tx_state_d = T_GAP;
        end
      end
      T_GAP: begin
        tx_state_d = (tx_left_q == 3'd0) ? T_IDLE : T_SEND;
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  // RX engine: pop queued bytes into a shifting accumulator until n bytes are in
  always_comb begin
    rx_state_d = rx_state_q;
    acc_d      = acc_q;
    rx_left_d  = rx_left_q;
    rd_d       = rd_q;
    rdone_d    = 1'b0;
    fifo_pop   = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        if (uart_renable) begin
          rx_left_d  = nbytes(uart_rsz);
          acc_d      = '0;
          rx_state_d = R_COLLECT;
        end
      end
      R_COLLECT: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          acc_d     = {acc_q[23:0], fifo_dout};
          rx_left_d = rx_left_q - 3'd1;
          if (rx_left_q == 3'd1) begin
            rd_d       = {acc_q[23:0], fifo_dout};
            rdone_d    = 1'b1;
            rx_state_d = R_DONE;
          end
        end
      end
      R_DONE: begin
        rx_state_d = R_IDLE;
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  // Overflow is sticky: a byte arriving to a full FIFO with no pop is lost
  always_comb begin
    ovf_d = ovf_q | (push_req & fifo_full & ~fifo_pop);
  end

  // State and registered outputs of both engines
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state_q <= T_IDLE;
      wd_q       <= '0;
      tx_left_q  <= '0;
      wdone_q    <= 1'b0;
      rx_state_q <= R_IDLE;
      acc_q      <= '0;
      rd_q       <= '0;
      rx_left_q  <= '0;
      rdone_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      wd_q       <= wd_d;
      tx_left_q  <= tx_left_d;
      wdone_q    <= wdone_d;
      rx_state_q <= rx_state_d;
      acc_q      <= acc_d;
      rd_q       <= rd_d;
      rx_left_q  <= rx_left_d;
      rdone_q    <= rdone_d;
      ovf_q      <= ovf_d;
    end
  end

  uart_io_fifo #(
    .DEPTH_LOG2(RX_DEPTH_LOG2)
  ) u_rx_fifo (
    .clk  (clk),
    .rstn (rstn),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  (push_byte),
    .dout (fifo_dout),
    .empty(fifo_empty),
    .full (fifo_full)
  );

endmodule
